// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: rising-edge capture, enable mask, fixed priority, claim/complete
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic               req_i,
    output logic [31:0]        data_o,
    output logic               ack_o,
    output logic               int_o,
    output logic [4:0]         int_id_o
);

    localparam logic [3:0] ADDR_ENABLE   = 4'h0;
    localparam logic [3:0] ADDR_PENDING  = 4'h4;
    localparam logic [3:0] ADDR_CLAIM    = 4'h8;
    localparam logic [3:0] ADDR_COMPLETE = 4'hC;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] rise;
    logic [4:0]         is_id;
    logic [4:0]         win_id;
    logic [31:0]        rd_data;
    logic               claim;
    logic               complete;
    logic               unused_bits;

    assign unused_bits = ^{addr_i[31:4], data_i[31:NUM_SRC]};

    // Scan from the top down so the lowest active index is the last to assign.
    always_comb begin
        active = pending & enable;
        win_id = 5'd0;
        win_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id    = 5'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign claim    = req_i && !we_i && (addr_i[3:0] == ADDR_CLAIM)
                      && (is_id == 5'd0) && (win_id != 5'd0);
    assign complete = req_i && we_i && (addr_i[3:0] == ADDR_COMPLETE)
                      && (data_i[4:0] == is_id);
    assign clr_mask = claim ? win_oh : '0;
    assign rise     = src_i & ~src_q;

    always_comb begin
        rd_data = 32'd0;
        case (addr_i[3:0])
            ADDR_ENABLE:   rd_data = 32'(enable);
            ADDR_PENDING:  rd_data = 32'(pending);
            ADDR_CLAIM:    rd_data = (is_id == 5'd0) ? 32'(win_id) : 32'd0;
            ADDR_COMPLETE: rd_data = 32'(is_id);
            default:       rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= '0;
            pending  <= '0;
            src_q    <= '0;
            is_id    <= 5'd0;
            data_o   <= 32'd0;
            ack_o    <= 1'b0;
            int_o    <= 1'b0;
            int_id_o <= 5'd0;
        end else begin
            src_q    <= src_i;
            // A fresh edge on the bit being claimed keeps it pending.
            pending  <= (pending & ~clr_mask) | rise;
            int_o    <= (is_id == 5'd0) && (|active);
            int_id_o <= (is_id == 5'd0) ? win_id : 5'd0;
            ack_o    <= req_i;
            data_o   <= (req_i && !we_i) ? rd_data : 32'd0;
            if (req_i && we_i && (addr_i[3:0] == ADDR_ENABLE)) begin
                enable <= data_i[NUM_SRC-1:0];
            end
            if (claim) begin
                is_id <= win_id;
            end else if (complete) begin
                is_id <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - vector table, corner sequences and randomized model check for int_ctrl
module tb_int_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   addr_i = '0;
    logic          we_i = 1'b0;
    logic          req_i = 1'b0;
    logic [31:0]   data_o;
    logic          ack_o;
    logic          int_o;
    logic [4:0]    int_id_o;

    int_ctrl #(.NUM_SRC(N)) dut (
        .clk(clk), .rst(rst), .src_i(src_i), .data_i(data_i), .addr_i(addr_i),
        .we_i(we_i), .req_i(req_i), .data_o(data_o), .ack_o(ack_o),
        .int_o(int_o), .int_id_o(int_id_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: registers as plain variables, IDs as integers.
    logic [N-1:0] m_en, m_pend, m_prev;
    int           m_is, m_id;
    logic [31:0]  m_data;
    logic         m_ack, m_int;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_prev = '0; m_is = 0; m_id = 0;
        m_data = '0; m_ack = 1'b0; m_int = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] s, input logic r, input logic w,
                              input logic [3:0] a, input logic [31:0] d);
        int win;
        logic [N-1:0] np, ne;
        int ni;
        win = lowest(m_pend & m_en);
        np = m_pend; ne = m_en; ni = m_is;
        m_int = (m_is == 0) && (win != 0);
        m_id = m_int ? win : 0;
        m_ack = r;
        m_data = '0;
        if (r && w) begin
            if (a == 4'h0) ne = d[N-1:0];
            if (a == 4'hC && int'(d[4:0]) == m_is) ni = 0;
        end else if (r) begin
            case (a)
                4'h0: m_data = 32'(m_en);
                4'h4: m_data = 32'(m_pend);
                4'h8: if (m_is == 0 && win != 0) begin
                          m_data = 32'(win);
                          np[win-1] = 1'b0;
                          ni = win;
                      end
                4'hC: m_data = 32'(m_is);
                default: m_data = '0;
            endcase
        end
        for (int i = 0; i < N; i++) if (s[i] && !m_prev[i]) np[i] = 1'b1;
        m_pend = np; m_en = ne; m_is = ni; m_prev = s;
    endtask

    task automatic step(input logic [N-1:0] s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        src_i = s; req_i = r; we_i = w; addr_i = a; data_i = d;
        @(posedge clk);
        model_edge(s, r, w, a[3:0], d);
        #1;
        chk("model data_o", data_o, m_data);
        chk("model ack_o", 32'(ack_o), 32'(m_ack));
        chk("model int_o", 32'(int_o), 32'(m_int));
        chk("model int_id_o", 32'(int_id_o), 32'(m_id));
    endtask

    typedef struct {
        logic [N-1:0] s;
        logic         r, w;
        logic [3:0]   a;
        logic [31:0]  d;
        logic [31:0]  e_data;
        logic         e_ack, e_int;
        logic [4:0]   e_id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] s, input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ea,
                       input logic ei, input logic [4:0] eid);
        vec_t v;
        v.s = s; v.r = r; v.w = w; v.a = a; v.d = d;
        v.e_data = ed; v.e_ack = ea; v.e_int = ei; v.e_id = eid;
        tbl.push_back(v);
    endtask

    initial begin
        logic [N-1:0] cur;
        int sel;
        logic [3:0] ra;
        logic [31:0] rd;
        logic [27:0] upper;

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a transaction with PENDING=0x05, IS_ID=3.
        step(8'h00, 1, 1, 32'h0, 32'h04);
        step(8'h04, 0, 0, 32'h0, 32'h0);
        step(8'h04, 0, 0, 32'h0, 32'h0);
        step(8'h04, 1, 0, 32'h8, 32'h0);
        chk("pre-reset claim", data_o, 32'd3);
        step(8'h00, 0, 0, 32'h0, 32'h0);
        step(8'h05, 0, 0, 32'h0, 32'h0);
        step(8'h05, 1, 0, 32'h4, 32'h0);
        chk("pre-reset pending", data_o, 32'h05);
        #2;
        rst = 1'b1;
        src_i = '0; req_i = 1'b0; we_i = 1'b0;
        #1;
        chk("async rst data_o", data_o, 32'd0);
        chk("async rst ack_o", 32'(ack_o), 32'd0);
        chk("async rst int_o", 32'(int_o), 32'd0);
        chk("async rst int_id_o", 32'(int_id_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(8'h00, 1, 0, 32'h0, 32'h0);
        chk("post-reset enable", data_o, 32'd0);
        step(8'h00, 1, 0, 32'h4, 32'h0);
        chk("post-reset pending", data_o, 32'd0);
        step(8'h00, 1, 0, 32'hC, 32'h0);
        chk("post-reset is_id", data_o, 32'd0);
        step(8'h00, 0, 0, 32'h0, 32'h0);
        chk("post-reset int_o", 32'(int_o), 32'd0);

        // single source
        add(8'h00,1,1,4'h0,32'h01, 32'h0,1,0,5'd0);
        add(8'h01,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h01,0,0,4'h0,32'h00, 32'h0,0,1,5'd1);
        add(8'h01,1,0,4'h8,32'h00, 32'h1,1,1,5'd1);
        add(8'h01,1,0,4'h4,32'h00, 32'h0,1,0,5'd0);
        add(8'h01,1,0,4'hC,32'h00, 32'h1,1,0,5'd0);
        add(8'h01,1,1,4'hC,32'h01, 32'h0,1,0,5'd0);
        add(8'h00,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        // priority
        add(8'h00,1,1,4'h0,32'hFF, 32'h0,1,0,5'd0);
        add(8'h24,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h24,0,0,4'h0,32'h00, 32'h0,0,1,5'd3);
        add(8'h24,1,0,4'h8,32'h00, 32'h3,1,1,5'd3);
        add(8'h24,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h24,1,1,4'hC,32'h03, 32'h0,1,0,5'd0);
        add(8'h24,0,0,4'h0,32'h00, 32'h0,0,1,5'd6);
        add(8'h24,1,0,4'h8,32'h00, 32'h6,1,1,5'd6);
        add(8'h24,1,1,4'hC,32'h06, 32'h0,1,0,5'd0);
        add(8'h00,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        // masking
        add(8'h00,1,1,4'h0,32'h00, 32'h0,1,0,5'd0);
        add(8'h10,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h10,1,0,4'h4,32'h00, 32'h10,1,0,5'd0);
        add(8'h10,1,0,4'h8,32'h00, 32'h0,1,0,5'd0);
        add(8'h10,1,1,4'h0,32'h10, 32'h0,1,0,5'd0);
        add(8'h10,0,0,4'h0,32'h00, 32'h0,0,1,5'd5);
        add(8'h10,1,0,4'h8,32'h00, 32'h5,1,1,5'd5);
        add(8'h10,1,1,4'hC,32'h05, 32'h0,1,0,5'd0);
        add(8'h00,1,1,4'h0,32'hFF, 32'h0,1,0,5'd0);
        // non-nesting and bad complete
        add(8'h02,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h02,0,0,4'h0,32'h00, 32'h0,0,1,5'd2);
        add(8'h02,1,0,4'h8,32'h00, 32'h2,1,1,5'd2);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h03,1,0,4'h8,32'h00, 32'h0,1,0,5'd0);
        add(8'h03,1,1,4'hC,32'h07, 32'h0,1,0,5'd0);
        add(8'h03,1,0,4'hC,32'h00, 32'h2,1,0,5'd0);
        add(8'h03,1,1,4'hC,32'h02, 32'h0,1,0,5'd0);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,1,5'd1);
        add(8'h03,1,0,4'h8,32'h00, 32'h1,1,1,5'd1);
        add(8'h03,1,1,4'hC,32'h01, 32'h0,1,0,5'd0);
        // collision and level hold
        add(8'h01,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h01,0,0,4'h0,32'h00, 32'h0,0,1,5'd2);
        add(8'h03,1,0,4'h8,32'h00, 32'h2,1,1,5'd2);
        add(8'h03,1,0,4'h4,32'h00, 32'h2,1,0,5'd0);
        add(8'h03,1,1,4'hC,32'h02, 32'h0,1,0,5'd0);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,1,5'd2);
        add(8'h03,1,0,4'h8,32'h00, 32'h2,1,1,5'd2);
        add(8'h03,1,1,4'hC,32'h02, 32'h0,1,0,5'd0);
        add(8'h03,0,0,4'h0,32'h00, 32'h0,0,0,5'd0);
        add(8'h03,1,0,4'h4,32'h00, 32'h0,1,0,5'd0);
        add(8'h03,1,0,4'h0,32'h00, 32'hFF,1,0,5'd0);
        add(8'h03,1,1,4'h4,32'hFF, 32'h0,1,0,5'd0);
        add(8'h03,1,0,4'h4,32'h00, 32'h0,1,0,5'd0);
        add(8'h03,1,0,4'h2,32'h00, 32'h0,1,0,5'd0);

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].r, tbl[i].w, {28'h0, tbl[i].a}, tbl[i].d);
            chk($sformatf("row%0d data_o", i), data_o, tbl[i].e_data);
            chk($sformatf("row%0d ack_o", i), 32'(ack_o), 32'(tbl[i].e_ack));
            chk($sformatf("row%0d int_o", i), 32'(int_o), 32'(tbl[i].e_int));
            chk($sformatf("row%0d int_id_o", i), 32'(int_id_o), 32'(tbl[i].e_id));
        end

        cur = 8'h03;
        for (int k = 0; k < 800; k++) begin
            cur = cur ^ N'($urandom & $urandom);
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: ra = 4'h0;
                1: ra = 4'h4;
                2: ra = 4'h8;
                3: ra = 4'hC;
                default: ra = 4'($urandom);
            endcase
            rd = $urandom;
            if (ra == 4'hC) rd = ($urandom_range(0, 1) == 1) ? 32'(m_is) : 32'($urandom_range(0, 8));
            upper = 28'($urandom);
            step(cur, ($urandom_range(0, 2) != 0), 1'($urandom), {upper, ra}, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
